// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding master for the peripheral bus.
// Takes one read/write command on a valid/ready port, runs the two-phase
// address/data handshake with the slave, and returns read data or a
// timeout error on a valid/ready response port. A 16-bit watchdog keeps a
// dead slave from hanging the requester.
module bus_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MASK_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [MASK_W-1:0] cmd_wem,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // peripheral bus
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [MASK_W-1:0] wem_o,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t              state_r,     state_nxt_s;
  logic [15:0]         wdog_r,      wdog_nxt_s;
  logic                is_write_r,  is_write_nxt_s;  // we_o is dropped after the address phase
  logic                req_nxt_s;
  logic                we_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic [DATA_W-1:0]   data_nxt_s;
  logic [MASK_W-1:0]   wem_nxt_s;
  logic                rsp_valid_nxt_s;
  logic [DATA_W-1:0]   rsp_rdata_nxt_s;
  logic                rsp_err_nxt_s;
  logic                wdog_expired_s;

  // A new command can only be taken while nothing is in flight.
  assign cmd_ready = (state_r == ST_IDLE);

  assign wdog_expired_s = (wdog_r == TIMEOUT_C);

  // Next-state and next-output decode; every register holds unless its state moves it.
  always_comb begin
    state_nxt_s     = state_r;
    wdog_nxt_s      = wdog_r;
    is_write_nxt_s  = is_write_r;
    req_nxt_s       = req_o;
    we_nxt_s        = we_o;
    addr_nxt_s      = addr_o;
    data_nxt_s      = data_o;
    wem_nxt_s       = wem_o;
    rsp_valid_nxt_s = rsp_valid;
    rsp_rdata_nxt_s = rsp_rdata;
    rsp_err_nxt_s   = rsp_err;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          is_write_nxt_s = cmd_we;
          req_nxt_s      = 1'b1;
          we_nxt_s       = cmd_we;
          addr_nxt_s     = cmd_addr;
          data_nxt_s     = cmd_wdata;
          wem_nxt_s      = cmd_wem;
          wdog_nxt_s     = 16'd0;
          state_nxt_s    = ST_ADDR;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end

      ST_ADDR: begin
        // A strobe coinciding with expiry wins over the timeout.
        if (addr_ok) begin
          req_nxt_s   = 1'b0;
          we_nxt_s    = 1'b0;
          wdog_nxt_s  = 16'd0;
          state_nxt_s = ST_DATA;
        end else if (wdog_expired_s) begin
          req_nxt_s       = 1'b0;
          we_nxt_s        = 1'b0;
          rsp_err_nxt_s   = 1'b1;
          rsp_rdata_nxt_s = '0;
          rsp_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_RESP;
        end else begin
          wdog_nxt_s  = wdog_r + 16'd1;
        end
      end

      ST_DATA: begin
        if (data_ok) begin
          rsp_rdata_nxt_s = is_write_r ? '0 : data_i;
          rsp_err_nxt_s   = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_RESP;
        end else if (wdog_expired_s) begin
          rsp_err_nxt_s   = 1'b1;
          rsp_rdata_nxt_s = '0;
          rsp_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_RESP;
        end else begin
          wdog_nxt_s  = wdog_r + 16'd1;
        end
      end

      ST_RESP: begin
        // No command is accepted in the handshake cycle: IDLE is entered first.
        if (rsp_ready) begin
          rsp_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s     = ST_RESP;
        end
      end

      default: begin
        req_nxt_s       = 1'b0;
        we_nxt_s        = 1'b0;
        rsp_valid_nxt_s = 1'b0;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

  // State, watchdog and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wdog_r     <= 16'd0;
      is_write_r <= 1'b0;
      req_o      <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      wem_o      <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wdog_r     <= wdog_nxt_s;
      is_write_r <= is_write_nxt_s;
      req_o      <= req_nxt_s;
      we_o       <= we_nxt_s;
      addr_o     <= addr_nxt_s;
      data_o     <= data_nxt_s;
      wem_o      <= wem_nxt_s;
      rsp_valid  <= rsp_valid_nxt_s;
      rsp_rdata  <= rsp_rdata_nxt_s;
      rsp_err    <= rsp_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator. A cycle-level slave model is
// driven from the bench; expected timing and payload for each transaction
// are computed up front from the handshake/timeout rules with plain
// arithmetic, then compared cycle by cycle against the DUT.
module tb_bus_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wem;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  wem_o;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] data_i;

  int n_checks = 0;
  int n_errors = 0;

  bus_initiator #(
    .ADDR_W (32),
    .DATA_W (32),
    .MASK_W (4),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wem  (cmd_wem),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .req_o    (req_o),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .wem_o    (wem_o),
    .addr_ok  (addr_ok),
    .data_ok  (data_ok),
    .data_i   (data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One complete transaction. a = cycles addr_ok is withheld while req is up,
  // d = extra DATA cycles before data_ok (0 = minimum latency), r = cycles
  // rsp_ready is withheld once the response is up, stray = slave keeps
  // pulsing data_ok after the response is produced.
  // Cycle n counts negedges after the command-accept edge.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wem, input logic [31:0] rdata,
                         input int a, input int d, input int r, input bit stray);
    bit          err;
    int          req_end;
    int          rc;
    int          hs;
    logic [31:0] exp_rd;
    if (a > TO) begin
      err = 1'b1; req_end = 1 + TO; rc = 2 + TO;
    end else if (d > TO) begin
      err = 1'b1; req_end = 1 + a;  rc = 3 + a + TO;
    end else begin
      err = 1'b0; req_end = 1 + a;  rc = 3 + a + d;
    end
    hs     = rc + r;
    exp_rd = (err || we) ? 32'd0 : rdata;

    @(negedge clk);
    chk_b("cmd_ready_before", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wem   = wem;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rsp_ready = 1'b0;

    for (int n = 1; n <= hs + 1; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_we    = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wem   = 4'($urandom);

      chk_b("req_o", req_o, 1'(n <= req_end));
      if (n <= req_end) chk_b("we_o", we_o, we);
      chk("addr_o", addr_o, addr);
      chk("data_o", data_o, wdata);
      chk("wem_o", 32'(wem_o), 32'(wem));
      chk_b("cmd_ready", cmd_ready, 1'(n > hs));
      chk_b("rsp_valid", rsp_valid, 1'(n >= rc && n <= hs));
      if (n >= rc && n <= hs) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk_b("rsp_err", rsp_err, err);
      end

      // slave and response-consumer behaviour for the coming edge
      addr_ok = req_o && (n - 1 >= a);
      data_ok = (!err && n == 2 + a + d) ||
                (stray && n >= rc) ||
                (n <= a && $urandom_range(0, 1) == 1);
      data_i  = (!err && n == 2 + a + d) ? rdata : $urandom;
      if (n >= hs)      rsp_ready = 1'b1;
      else if (n < rc)  rsp_ready = 1'($urandom_range(0, 1));
      else              rsp_ready = 1'b0;
    end
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int a;
    int d;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 32'd0;
    cmd_wdata = 32'd0;
    cmd_wem   = 4'd0;
    rsp_ready = 1'b0;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    data_i    = 32'd0;

    // reset state
    repeat (2) @(negedge clk);
    chk_b("rst_req_o", req_o, 1'b0);
    chk_b("rst_we_o", we_o, 1'b0);
    chk("rst_addr_o", addr_o, 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_wem_o", 32'(wem_o), 32'd0);
    chk_b("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk_b("rst_rsp_err", rsp_err, 1'b0);
    chk_b("rst_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;

    // write to a timer-like slave, minimum latency
    run_txn(1'b1, 32'h1000_0008, 32'h0000_0064, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    // read, data_ok four cycles after addr_ok
    run_txn(1'b0, 32'h1000_0004, 32'h1234_5678, 4'h0, 32'h0000_0005, 0, 3, 0, 1'b0);
    // addr_ok stalled three cycles
    run_txn(1'b1, 32'h2000_0010, 32'hA5A5_5A5A, 4'h3, 32'h0, 3, 0, 0, 1'b0);
    // data phase timeout, slave then pulses stray data_ok
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 100, 1, 1'b1);
    // next command completes normally
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'h0, 32'h0BAD_CAFE, 1, 1, 0, 1'b0);
    // rsp_ready withheld five cycles
    run_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 32'h7777_1111, 0, 0, 5, 1'b0);
    // strobes arriving exactly at the watchdog limit win
    run_txn(1'b0, 32'h5000_0000, 32'h0, 4'h0, 32'h1357_9BDF, TO, 0, 0, 1'b0);
    run_txn(1'b0, 32'h5000_0004, 32'h0, 4'h0, 32'h2468_ACE0, 0, TO, 0, 1'b0);
    // address phase timeout
    run_txn(1'b1, 32'h6000_0000, 32'hFFFF_0000, 4'hC, 32'h0, TO + 1, 0, 2, 1'b0);

    // reset during the data phase
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h7000_0000;
    cmd_wdata = 32'h0;
    cmd_wem   = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_b("mid_req_up", req_o, 1'b1);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    chk_b("mid_req_down", req_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_b("mid_rst_req_o", req_o, 1'b0);
    chk("mid_rst_addr_o", addr_o, 32'd0);
    chk_b("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk_b("mid_rst_cmd_ready", cmd_ready, 1'b1);
    data_ok = 1'b1;
    data_i  = 32'h9999_9999;
    @(negedge clk);
    data_ok = 1'b0;
    chk_b("late_data_ok_rsp_valid", rsp_valid, 1'b0);
    chk_b("late_data_ok_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    chk_b("late_data_ok_rsp_valid2", rsp_valid, 1'b0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
      d = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 4);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom,
              a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
